// File: rtl/fir_out_requant.sv
// -----------------------------------------------------------------------------
// fir_out_requant
//
// Output stage for the symmetric FIR cores. Each full-precision IN_W-bit
// sample is rounded (half-up) and arithmetically right-shifted by SHIFT. The
// result is saturated to OUT_W bits and buffered in a DEPTH-entry FIFO. The
// FIFO head is presented on a valid/ready stream. The FIR cores cannot be
// stalled, so a sample that arrives at a full FIFO with no pop in the same
// cycle is dropped and recorded in the sticky ovf flag.
//
// Ports:
//   clk        clock, all state on the rising edge
//   rst        asynchronous active-high reset
//   in_valid   in_data carries a new filter sample this cycle
//   in_data    signed IN_W-bit filter sample
//   out_valid  FIFO head holds a sample (level != 0)
//   out_ready  downstream accepts the head this cycle
//   out_data   signed OUT_W-bit requantized sample at the FIFO head
//   out_sat    saturation flag stored with the head sample
//   level      FIFO occupancy, 0..DEPTH
//   ovf        sticky: a sample was dropped because the FIFO was full
//   ovf_clr    clears ovf (a drop in the same cycle wins)
//   sat_count  (only with FIR_REQUANT_SATCNT_EN) saturating count of pushes
//              carrying sat=1, including dropped ones; cleared by ovf_clr
//
// Optional feature macro: FIR_REQUANT_SATCNT_EN
// -----------------------------------------------------------------------------
module fir_out_requant #(
   parameter int IN_W  = 32,
   parameter int OUT_W = 16,
   parameter int SHIFT = 15,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     in_valid,
   input  logic [IN_W-1:0]          in_data,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [OUT_W-1:0]         out_data,
   output logic                     out_sat,
   output logic [$clog2(DEPTH):0]   level,
   input  logic                     ovf_clr,
`ifdef FIR_REQUANT_SATCNT_EN
   output logic [15:0]              sat_count,
`endif
   output logic                     ovf
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;
   localparam int EW = OUT_W + 1;   // {sat, data}

   localparam logic signed [IN_W:0] RND  = (IN_W+1)'(1) << (SHIFT - 1);
   localparam logic signed [IN_W:0] QMAX = (IN_W+1)'((1 << (OUT_W - 1)) - 1);
   localparam logic signed [IN_W:0] QMIN = -QMAX - (IN_W+1)'(1);

   // Round half-up then shift. The sum is formed one bit wider than the
   // input so adding the rounding constant to the most positive sample
   // cannot wrap.
   function automatic logic signed [IN_W:0] round_shift(input logic [IN_W-1:0] x);
      logic signed [IN_W:0] r;
      r = {x[IN_W-1], x};
      r = r + RND;
      return r >>> SHIFT;
   endfunction

   // Clamp to the signed OUT_W range; the MSB of the result is the sat flag.
   function automatic logic [EW-1:0] sat_out(input logic signed [IN_W:0] q);
      logic [EW-1:0] res;
      if (q > QMAX) begin
         res = {1'b1, 1'b0, {(OUT_W-1){1'b1}}};
      end else if (q < QMIN) begin
         res = {1'b1, 1'b1, {(OUT_W-1){1'b0}}};
      end else begin
         res = {1'b0, q[OUT_W-1:0]};
      end
      return res;
   endfunction

   // ---------------------------------------------------------------- stage 1
   logic                   vld_p1_q, vld_p1_d;
   logic signed [IN_W:0]   q_p1_q, q_p1_d;

   // ---------------------------------------------------------------- stage 2
   logic                   vld_p2_q, vld_p2_d;
   logic [EW-1:0]          ent_p2_q, ent_p2_d;

   // ---------------------------------------------------------------- FIFO
   logic [EW-1:0]          mem_q [DEPTH];
   logic [AW-1:0]          wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]          rd_ptr_q, rd_ptr_d;
   logic [LW-1:0]          level_q, level_d;
   logic                   ovf_q, ovf_d;
   logic                   push, pop, full, wr_en, drop;
   logic [EW-1:0]          head;

   always_comb begin
      vld_p1_d = in_valid;
      q_p1_d   = q_p1_q;
      if (in_valid) begin
         q_p1_d = round_shift(in_data);
      end

      vld_p2_d = vld_p1_q;
      ent_p2_d = ent_p2_q;
      if (vld_p1_q) begin
         ent_p2_d = sat_out(q_p1_q);
      end
   end

   always_comb begin
      push  = vld_p2_q;
      full  = (level_q == LW'(DEPTH));
      pop   = out_valid && out_ready;
      // A full FIFO still accepts a push when the head leaves in the same cycle.
      wr_en = push && (!full || pop);
      drop  = push && full && !pop;

      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      level_d  = level_q;
      if (wr_en) begin
         wr_ptr_d = wr_ptr_q + AW'(1);
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + AW'(1);
      end
      case ({wr_en, pop})
         2'b10:   level_d = level_q + LW'(1);
         2'b01:   level_d = level_q - LW'(1);
         default: level_d = level_q;
      endcase

      ovf_d = ovf_q;
      if (drop) begin
         ovf_d = 1'b1;
      end else if (ovf_clr) begin
         ovf_d = 1'b0;
      end
   end

   // Control state: valid bits, pointers, occupancy and flags.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vld_p1_q <= 1'b0;
         vld_p2_q <= 1'b0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
         ovf_q    <= 1'b0;
      end else begin
         vld_p1_q <= vld_p1_d;
         vld_p2_q <= vld_p2_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
         ovf_q    <= ovf_d;
      end
   end

   // Datapath state is qualified by the valid bits and level, so it needs
   // no reset.
   always_ff @(posedge clk) begin
      q_p1_q   <= q_p1_d;
      ent_p2_q <= ent_p2_d;
      if (wr_en) begin
         mem_q[wr_ptr_q] <= ent_p2_q;
      end
   end

   // ---------------------------------------------------------------- output
   // Head is read combinationally; it is forced to zero while empty so the
   // outputs are clean straight out of reset.
   assign head      = mem_q[rd_ptr_q];
   assign out_valid = (level_q != '0);
   assign out_data  = out_valid ? head[OUT_W-1:0] : '0;
   assign out_sat   = out_valid & head[OUT_W];
   assign level     = level_q;
   assign ovf       = ovf_q;

`ifdef FIR_REQUANT_SATCNT_EN
   logic [15:0] sat_cnt_q, sat_cnt_d;

   // Counts every saturated push, dropped or not; an increment beats a clear.
   always_comb begin
      sat_cnt_d = sat_cnt_q;
      if (push && ent_p2_q[OUT_W]) begin
         if (sat_cnt_q != 16'hFFFF) begin
            sat_cnt_d = sat_cnt_q + 16'd1;
         end
      end else if (ovf_clr) begin
         sat_cnt_d = '0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sat_cnt_q <= '0;
      end else begin
         sat_cnt_q <= sat_cnt_d;
      end
   end

   assign sat_count = sat_cnt_q;
`endif

endmodule
